timer_regs: RTL and testbench
=============================

Name: timer_regs

Overview:
- Bus-side register block for the `timing` counter.
- Decodes a simple req/ack register bus from the host.
- Drives the `ro_*` control fields consumed by `timing`, and captures its `rf_*` status fields.
- Turns `rf_int` into a sticky, maskable, write-1-to-clear interrupt line. One instance per timer.

Parameters:
- ADDR_W, 4, word-address width of `bus_addr`
- TERM_RST, 32'd0, reset value of the TERMCOUNT shadow and of `ro_termcount`

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- bus_req  in  1  host request; held high until `bus_ack` is seen
- bus_wr  in  1  1 = write, 0 = read; stable while `bus_req` is high
- bus_addr  in  ADDR_W  word address
- bus_wdata  in  32  write data
- bus_ack  out  1  one-cycle acknowledge
- bus_rdata  out  32  read data, valid in the `bus_ack` cycle
- ro_trig_start  out  1  one-cycle start pulse to the timer
- ro_trig_halt  out  1  one-cycle halt pulse to the timer
- ro_mode  out  1  timer mode bit
- ro_termcount  out  32  terminal count to the timer
- rf_status  in  1  timer running flag
- rf_currcount  in  32  timer current count
- rf_int  in  1  timer terminal-count indication
- irq  out  1  interrupt to host, level

Behaviour:
- Register map (word addresses):
  - 0x0 CTRL: bit0 START (write-only pulse, reads 0), bit1 HALT (write-only pulse, reads 0), bit2 MODE (RW), bit3 INT_EN (RW).
  - 0x1 TERMCOUNT: RW shadow register.
  - 0x2 STATUS: RO; bit0 = `rf_status`, bit1 = int_pending.
  - 0x3 CURRCOUNT: RO; returns `rf_currcount` registered at accept.
  - 0x4 INTCLR: write 1 to bit0 clears int_pending; reads return {31'b0, int_pending}.
  - All other addresses: reads return 0, writes are ignored, the access is still acked.
- Bus FSM:
  - States: IDLE, ACK, HOLD.
  - IDLE -> ACK when `bus_req` = 1. The access is accepted in this transition cycle: the write takes effect and the read data is registered.
  - ACK drives `bus_ack` = 1 for exactly one cycle, then -> HOLD.
  - HOLD -> IDLE once `bus_req` = 0.
  - Latency from `bus_req` rising to `bus_ack` is 1 cycle. The earliest next accept is 1 cycle after the request drops.
  - `bus_req` staying high in HOLD never causes a second access.
- Trigger pulses:
  - A CTRL write with bit0 = 1 asserts `ro_trig_start` for exactly 1 cycle, in the ACK cycle.
  - HALT behaves the same way and asserts `ro_trig_halt`.
  - If bits 0 and 1 are both 1 in the same write: HALT pulses and START is suppressed.
  - Pulses are never wider than 1 cycle and never repeat without a new write.
- Termcount:
  - TERMCOUNT writes update the shadow only.
  - `ro_termcount` loads from the shadow on any cycle where `rf_status` = 0, and in the cycle `ro_trig_start` is high.
  - While the timer runs, `ro_termcount` is frozen. Reading TERMCOUNT returns the shadow.
- `ro_mode` equals CTRL.MODE directly and changes in the ACK cycle of the write.
- Interrupt:
  - `rf_int` is registered once.
  - A rising edge (`rf_int` = 1, previous sample = 0) sets int_pending.
  - An INTCLR write with bit0 = 1 clears int_pending.
  - If set and clear occur in the same cycle, set wins.
  - `irq` = int_pending & INT_EN, registered (1 cycle after int_pending).
  - Clearing INT_EN masks `irq` but does not clear int_pending.
- Reset (asserted, `reset` = 0):
  - `bus_ack` = 0, `bus_rdata` = 0, `ro_trig_start` = 0, `ro_trig_halt` = 0, `ro_mode` = 0.
  - `ro_termcount` = TERM_RST, shadow = TERM_RST, INT_EN = 0, int_pending = 0, `irq` = 0.
  - FSM returns to IDLE and the `rf_int` edge register = 0.
  - Reset mid-transaction aborts it with no ack. The host must re-issue the access.

Optional Feature:
- Macro: TIMER_REGS_CAPTURE_EN.
- When defined:
  - Adds register 0x5 CAPTURE (RO, reset 0).
  - CAPTURE loads `rf_currcount` on every `rf_int` rising edge, in the same cycle int_pending is set.
  - An edge that arrives while int_pending is already 1 still overwrites CAPTURE.
- When undefined: 0x5 is unmapped and reads 0; no capture flops are instantiated.

Test Plan:
- Reset released; read 0x1 -> 0x00000000. Read 0x0 -> 0x0. `irq` = 0.
- Write 0x1 = 10, then write 0x0 = 0x1 with `rf_status` = 0 -> `ro_termcount` = 10 and exactly one `ro_trig_start` pulse in the ack cycle. `bus_req` held 5 extra cycles -> no further ack or pulse.
- With `rf_status` = 1: write 0x1 = 50 -> `ro_termcount` stays 10 and a read of 0x1 returns 50. Drop `rf_status` -> `ro_termcount` = 50 on the next cycle.
- Write 0x0 = 0x3 -> `ro_trig_halt` pulses once and `ro_trig_start` stays 0.
- Write 0x0 = 0x8 (INT_EN). Pulse `rf_int` -> STATUS bit1 = 1 and `irq` = 1. Write 0x4 = 1 in the same cycle as a new `rf_int` edge -> pending stays 1. A later write of 0x4 = 1 -> `irq` = 0 within 2 cycles.
- With TIMER_REGS_CAPTURE_EN: `rf_currcount` = 0x1234 at an `rf_int` edge -> a read of 0x5 returns 0x1234. Without the macro, a read of 0x5 returns 0.

Source files
------------

// File: rtl/timer_regs.sv
// timer_regs: host register block for one timer; optional CAPTURE register via TIMER_REGS_CAPTURE_EN
module timer_regs #(
    parameter int          ADDR_W   = 4,
    parameter logic [31:0] TERM_RST = 32'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_req,
    input  logic              bus_wr,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic              bus_ack,
    output logic [31:0]       bus_rdata,
    output logic              ro_trig_start,
    output logic              ro_trig_halt,
    output logic              ro_mode,
    output logic [31:0]       ro_termcount,
    input  logic              rf_status,
    input  logic [31:0]       rf_currcount,
    input  logic              rf_int,
    output logic              irq
);
    typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;
    state_t      state, state_nx;
    logic        acc, wr_ctrl, wr_term, clr, int_edge;
    logic        int_en, int_pend, rf_int_q;
    logic [31:0] shadow, rd;
`ifdef TIMER_REGS_CAPTURE_EN
    logic [31:0] capture;
`endif
    assign acc      = state == IDLE && bus_req;
    assign wr_ctrl  = acc && bus_wr && bus_addr == ADDR_W'(0);
    assign wr_term  = acc && bus_wr && bus_addr == ADDR_W'(1);
    assign clr      = acc && bus_wr && bus_addr == ADDR_W'(4) && bus_wdata[0];
    assign int_edge = rf_int && !rf_int_q;
    // Next state and ack; HOLD absorbs a request still high after the ack
    always_comb begin
        state_nx = acc ? ACK : state == ACK ? HOLD : (state == HOLD && !bus_req) ? IDLE : state;
        bus_ack  = state == ACK;
    end
    // Bus FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end
    // Read mux sampled at accept
    always_comb begin
        rd = 32'd0;
        case (bus_addr)
            ADDR_W'(0): rd = {28'd0, int_en, ro_mode, 2'b00};
            ADDR_W'(1): rd = shadow;
            ADDR_W'(2): rd = {30'd0, int_pend, rf_status};
            ADDR_W'(3): rd = rf_currcount;
            ADDR_W'(4): rd = {31'd0, int_pend};
`ifdef TIMER_REGS_CAPTURE_EN
            ADDR_W'(5): rd = capture;
`endif
            default:    rd = 32'd0;
        endcase
    end
    // Control fields, read data and one-cycle trigger pulses; HALT overrides START
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_rdata     <= 32'd0;
            ro_trig_start <= 1'b0;
            ro_trig_halt  <= 1'b0;
            ro_mode       <= 1'b0;
            int_en        <= 1'b0;
            shadow        <= TERM_RST;
        end else begin
            ro_trig_start <= wr_ctrl && bus_wdata[0] && !bus_wdata[1];
            ro_trig_halt  <= wr_ctrl && bus_wdata[1];
            if (acc && !bus_wr) bus_rdata <= rd;
            if (wr_ctrl) {int_en, ro_mode} <= bus_wdata[3:2];
            if (wr_term) shadow <= bus_wdata;
        end
    end
    // Terminal count follows the shadow only while the timer is idle or being started
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                         ro_termcount <= TERM_RST;
        else if (!rf_status || ro_trig_start) ro_termcount <= shadow;
    end
    // Sticky interrupt: rising edge sets (wins over clear), INTCLR clears, irq masked by INT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_int_q <= 1'b0;
            int_pend <= 1'b0;
            irq      <= 1'b0;
        end else begin
            rf_int_q <= rf_int;
            int_pend <= int_edge ? 1'b1 : clr ? 1'b0 : int_pend;
            irq      <= int_pend && int_en;
        end
    end
`ifdef TIMER_REGS_CAPTURE_EN
    // Snapshot the current count on every interrupt edge, even if already pending
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        capture <= 32'd0;
        else if (int_edge) capture <= rf_currcount;
    end
`endif
endmodule

// File: tb/tb_timer_regs.sv
// tb_timer_regs: scoreboard bench for timer_regs
module tb_timer_regs;
    logic        clk = 0, reset = 0;
    logic        bus_req = 0, bus_wr = 0;
    logic [3:0]  bus_addr = 0;
    logic [31:0] bus_wdata = 0;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        ro_trig_start, ro_trig_halt, ro_mode;
    logic [31:0] ro_termcount;
    logic        rf_status = 0, rf_int = 0;
    logic [31:0] rf_currcount = 0;
    logic        irq;
    int          errors = 0, checks = 0;
    int          start_any = 0, start_ack = 0, halt_any = 0;
    logic [36:0] sb[$];

    timer_regs #(.ADDR_W(4), .TERM_RST(32'd0)) dut (
        .clk(clk), .reset(reset), .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .ro_trig_start(ro_trig_start), .ro_trig_halt(ro_trig_halt), .ro_mode(ro_mode),
        .ro_termcount(ro_termcount), .rf_status(rf_status), .rf_currcount(rf_currcount),
        .rf_int(rf_int), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", n, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each ack and counts trigger pulses
    always @(negedge clk) begin
        logic [36:0] e;
        if (bus_ack) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack required none");
            end else begin
                e = sb.pop_front();
                if (e[36]) chk($sformatf("read_addr_%0h", e[35:32]), bus_rdata, e[31:0]);
            end
        end
        if (ro_trig_start) begin
            start_any++;
            if (bus_ack) start_ack++;
        end
        if (ro_trig_halt) halt_any++;
    end

    task automatic bus(input bit wr, input logic [3:0] a, input logic [31:0] d, input int hold);
        bit got = 0;
        sb.push_back({~wr, a, d});
        bus_wr = wr; bus_addr = a; bus_wdata = wr ? d : 32'd0; bus_req = 1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = bus_ack;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout addr=%0h: got no ack required ack", a);
            void'(sb.pop_back());
        end
        repeat (hold) @(negedge clk);
        @(posedge clk) #1 bus_req = 0;
        @(posedge clk) #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus(1, a, d, 0);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp);
        bus(0, a, exp, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", {31'd0, bus_ack}, 0);
        chk("rst_rdata", bus_rdata, 0);
        chk("rst_termcount", ro_termcount, 0);
        chk("rst_mode", {31'd0, ro_mode}, 0);
        chk("rst_irq", {31'd0, irq}, 0);
        @(posedge clk) #1 reset = 1;
        rd(4'h1, 32'h0);
        rd(4'h0, 32'h0);
        chk("irq_idle", {31'd0, irq}, 0);

        wr(4'h1, 32'd10);
        start_any = 0; start_ack = 0; halt_any = 0;
        bus(1, 4'h0, 32'h1, 5);
        chk("start_pulses", start_any, 1);
        chk("start_in_ack", start_ack, 1);
        chk("halt_none", halt_any, 0);
        chk("termcount_10", ro_termcount, 32'd10);
        rd(4'h0, 32'h0);

        rf_status = 1;
        wr(4'h1, 32'd50);
        chk("termcount_frozen", ro_termcount, 32'd10);
        rd(4'h1, 32'd50);
        rd(4'h2, 32'h1);
        rf_status = 0;
        @(posedge clk) #1;
        chk("termcount_50", ro_termcount, 32'd50);

        start_any = 0; halt_any = 0;
        wr(4'h0, 32'h3);
        chk("halt_pulses", halt_any, 1);
        chk("start_suppressed", start_any, 0);

        wr(4'h0, 32'hC);
        chk("mode_set", {31'd0, ro_mode}, 1);
        rd(4'h0, 32'hC);
        rf_int = 1;
        repeat (2) @(posedge clk);
        #1 rf_int = 0;
        @(posedge clk) #1;
        rd(4'h2, 32'h2);
        chk("irq_set", {31'd0, irq}, 1);
        rf_int = 1;
        wr(4'h4, 32'h1);
        rf_int = 0;
        rd(4'h2, 32'h2);
        wr(4'h0, 32'h4);
        chk("irq_masked", {31'd0, irq}, 0);
        rd(4'h4, 32'h1);
        wr(4'h0, 32'hC);
        chk("irq_unmasked", {31'd0, irq}, 1);
        wr(4'h4, 32'h1);
        chk("irq_cleared", {31'd0, irq}, 0);
        rd(4'h2, 32'h0);

        rf_currcount = 32'h1234;
        rf_int = 1;
        @(posedge clk) #1 rf_int = 0;
        rf_currcount = 32'hABCD;
        @(posedge clk) #1;
`ifdef TIMER_REGS_CAPTURE_EN
        rd(4'h5, 32'h1234);
`else
        rd(4'h5, 32'h0);
`endif
        rd(4'h3, 32'hABCD);
        wr(4'h7, 32'hFFFF_FFFF);
        rd(4'h7, 32'h0);
        rd(4'h1, 32'd50);

        bus_wr = 0; bus_addr = 4'h1; bus_req = 1;
        #2 reset = 0;
        @(negedge clk);
        chk("abort_no_ack", {31'd0, bus_ack}, 0);
        chk("abort_termcount", ro_termcount, 0);
        chk("abort_mode", {31'd0, ro_mode}, 0);
        chk("abort_irq", {31'd0, irq}, 0);
        @(posedge clk) #1 reset = 1; bus_req = 0;
        @(posedge clk) #1;
        rd(4'h1, 32'h0);
        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang required finish");
        $fatal(1, "timeout");
    end
endmodule
